// File: rtl/rvsteel_loader.sv
// Serial boot loader: receives a framed image over UART 8N1 and writes it to RAM
// through a simple request/response bus, holding the core in halt until loaded.
module rvsteel_loader #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned UART_BAUD_RATE  = 9600,
  parameter logic [31:0] BASE_ADDRESS    = 32'h00000000,
  parameter int unsigned MAX_SIZE        = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [31:0] rw_address,
  output logic [31:0] write_data,
  output logic [3:0]  write_strobe,
  output logic        write_request,
  input  logic        write_response,
  output logic        core_halt,
  output logic        load_error
);

  localparam int unsigned BIT_CYCLES  = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CNT_W       = $clog2(BIT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_MAGIC, LEN, DATA, CSUM, FLUSH, DONE} state_t;

  // uart_rx is asynchronous to clock; resynchronize before use
  logic rx_meta, rx_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_valid, rx_valid_n;
  logic             rx_ferr, rx_ferr_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_valid <= rx_valid_n;
      rx_ferr  <= rx_ferr_n;
    end
  end

  // Receiver: confirm start at half bit, then sample each bit one period later
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_valid_n = 1'b0;
    rx_ferr_n  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_sync) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CNT_W'(HALF_CYCLES - 1)) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_W'(BIT_CYCLES - 1)) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_W'(BIT_CYCLES - 1)) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          rx_valid_n = rx_sync;
          rx_ferr_n  = !rx_sync;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  state_t      state, state_n;
  logic [31:0] len, len_n;
  logic [1:0]  len_idx, len_idx_n;
  logic [31:0] byte_cnt, byte_cnt_n;
  logic [7:0]  sum, sum_n;
  logic [31:0] asm_word, asm_word_n;
  logic [3:0]  asm_strobe, asm_strobe_n;
  logic [31:0] rw_address_n, write_data_n;
  logic [3:0]  write_strobe_n;
  logic        write_request_n, core_halt_n, load_error_n;

  logic [1:0]  lane_c;
  logic [31:0] word_c;
  logic [3:0]  strobe_c;
  logic [31:0] len_full_c;
  logic        last_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= WAIT_MAGIC;
      len           <= '0;
      len_idx       <= '0;
      byte_cnt      <= '0;
      sum           <= '0;
      asm_word      <= '0;
      asm_strobe    <= '0;
      rw_address    <= '0;
      write_data    <= '0;
      write_strobe  <= '0;
      write_request <= 1'b0;
      core_halt     <= 1'b1;
      load_error    <= 1'b0;
    end else begin
      state         <= state_n;
      len           <= len_n;
      len_idx       <= len_idx_n;
      byte_cnt      <= byte_cnt_n;
      sum           <= sum_n;
      asm_word      <= asm_word_n;
      asm_strobe    <= asm_strobe_n;
      rw_address    <= rw_address_n;
      write_data    <= write_data_n;
      write_strobe  <= write_strobe_n;
      write_request <= write_request_n;
      core_halt     <= core_halt_n;
      load_error    <= load_error_n;
    end
  end

  // Assembly word with the incoming byte merged into its lane
  always_comb begin
    lane_c     = byte_cnt[1:0];
    word_c     = asm_word;
    word_c[{lane_c, 3'b000} +: 8] = rx_shift;
    strobe_c   = asm_strobe | (4'b0001 << lane_c);
    len_full_c = {rx_shift, len[23:0]};
    last_c     = (byte_cnt + 32'd1) == len;
  end

  always_comb begin
    state_n         = state;
    len_n           = len;
    len_idx_n       = len_idx;
    byte_cnt_n      = byte_cnt;
    sum_n           = sum;
    asm_word_n      = asm_word;
    asm_strobe_n    = asm_strobe;
    rw_address_n    = rw_address;
    write_data_n    = write_data;
    write_strobe_n  = write_strobe;
    write_request_n = write_request;
    core_halt_n     = core_halt;
    load_error_n    = load_error;

    // An acknowledged write frees the pending slot this cycle
    if (write_request && write_response) write_request_n = 1'b0;

    case (state)
      WAIT_MAGIC: begin
        if (rx_valid && rx_shift == 8'hA5) begin
          state_n      = LEN;
          len_n        = '0;
          len_idx_n    = '0;
          byte_cnt_n   = '0;
          sum_n        = '0;
          asm_word_n   = '0;
          asm_strobe_n = '0;
        end
      end
      LEN: begin
        if (rx_valid) begin
          len_n[{len_idx, 3'b000} +: 8] = rx_shift;
          len_idx_n = len_idx + 2'd1;
          if (len_idx == 2'd3) begin
            if (len_full_c > 32'(MAX_SIZE)) begin
              load_error_n = 1'b1;
              state_n      = WAIT_MAGIC;
            end else if (len_full_c == 32'd0) begin
              state_n = CSUM;
            end else begin
              state_n = DATA;
            end
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          sum_n      = sum + rx_shift;
          byte_cnt_n = byte_cnt + 32'd1;
          if (lane_c == 2'd3 || last_c) begin
            if (write_request && !write_response) begin
              load_error_n = 1'b1;
              state_n      = WAIT_MAGIC;
            end else begin
              write_request_n = 1'b1;
              rw_address_n    = BASE_ADDRESS + {byte_cnt[31:2], 2'b00};
              write_data_n    = word_c;
              write_strobe_n  = strobe_c;
              asm_word_n      = '0;
              asm_strobe_n    = '0;
              if (last_c) state_n = CSUM;
            end
          end else begin
            asm_word_n   = word_c;
            asm_strobe_n = strobe_c;
          end
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_shift == sum) begin
            state_n = FLUSH;
          end else begin
            load_error_n = 1'b1;
            state_n      = WAIT_MAGIC;
          end
        end
      end
      FLUSH: begin
        if (!write_request) begin
          state_n      = DONE;
          core_halt_n  = 1'b0;
          load_error_n = 1'b0;
        end
      end
      DONE: core_halt_n = 1'b0;
      default: state_n = WAIT_MAGIC;
    endcase

    // A framing error aborts any frame in progress; once loaded the line is ignored
    if (rx_ferr && state != DONE) begin
      load_error_n = 1'b1;
      state_n      = WAIT_MAGIC;
    end
  end

endmodule

// File: tb/tb_rvsteel_loader.sv
// Directed bench for rvsteel_loader: framed images over UART with a simple bus responder.
module tb_rvsteel_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        uart_rx;
  logic [31:0] rw_address;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;
  logic        core_halt;
  logic        load_error;

  int checks = 0;
  int errors = 0;

  int resp_delay = 2;
  bit resp_hold  = 1'b0;
  int req_age    = 0;
  int wr_cnt     = 0;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  logic [3:0]  wr_strb [0:63];
  int wr_base;

  rvsteel_loader #(
    .CLOCK_FREQUENCY(16),
    .UART_BAUD_RATE (1),
    .BASE_ADDRESS   (32'h00000100),
    .MAX_SIZE       (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .rw_address    (rw_address),
    .write_data    (write_data),
    .write_strobe  (write_strobe),
    .write_request (write_request),
    .write_response(write_response),
    .core_halt     (core_halt),
    .load_error    (load_error)
  );

  always #5 clock = ~clock;

  // Bus responder: acknowledges a request after resp_delay cycles, logs what it accepted
  initial begin : responder
    write_response = 1'b0;
    forever begin
      @(negedge clock);
      if (write_response) begin
        write_response = 1'b0;
        req_age = 0;
      end else if (write_request && !resp_hold) begin
        req_age++;
        if (req_age >= resp_delay) begin
          write_response = 1'b1;
          wr_addr[wr_cnt[5:0]] = rw_address;
          wr_data[wr_cnt[5:0]] = write_data;
          wr_strb[wr_cnt[5:0]] = write_strobe;
          wr_cnt++;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    chk({tag, "_addr"}, wr_addr[idx[5:0]], a);
    chk({tag, "_data"}, wr_data[idx[5:0]], d);
    chk({tag, "_strb"}, 32'(wr_strb[idx[5:0]]), 32'(s));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clock);
    end
    uart_rx = stop_ok;
    repeat (16) @(negedge clock);
    uart_rx = 1'b1;
    if (!stop_ok) repeat (32) @(negedge clock);
  endtask

  task automatic send_frame_hdr(input logic [31:0] len);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    wr_base = wr_cnt;
  endtask

  initial begin
    reset   = 1'b1;
    uart_rx = 1'b1;
    wr_base = 0;
    repeat (4) @(negedge clock);

    // Reset state
    chk("rst_core_halt", 32'(core_halt), 32'd1);
    chk("rst_load_error", 32'(load_error), 32'd0);
    chk("rst_write_request", 32'(write_request), 32'd0);
    chk("rst_rw_address", rw_address, 32'h0);
    chk("rst_write_data", write_data, 32'h0);
    chk("rst_write_strobe", 32'(write_strobe), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Stray byte then oversized length: error right after 4th length byte, no write
    send_byte(8'h5A, 1'b1);
    chk("stray_ignored_err", 32'(load_error), 32'd0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("len3_no_err_yet", 32'(load_error), 32'd0);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clock);
    chk("oversize_err", 32'(load_error), 32'd1);
    chk("oversize_no_write", 32'(wr_cnt - wr_base), 32'd0);
    chk("oversize_req", 32'(write_request), 32'd0);
    chk("oversize_halt", 32'(core_halt), 32'd1);

    // Framing error sets load_error
    do_reset();
    chk("ferr_pre", 32'(load_error), 32'd0);
    send_byte(8'hA5, 1'b0);
    chk("ferr_err", 32'(load_error), 32'd1);
    chk("ferr_halt", 32'(core_halt), 32'd1);

    // Bad checksum, then a good 3-byte frame recovers
    do_reset();
    send_frame_hdr(32'd2);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h04, 1'b1);
    repeat (4) @(negedge clock);
    chk("badsum_wr_count", 32'(wr_cnt - wr_base), 32'd1);
    chk_write("badsum_w0", wr_base, 32'h100, 32'h00000201, 4'b0011);
    chk("badsum_err", 32'(load_error), 32'd1);
    chk("badsum_halt", 32'(core_halt), 32'd1);
    send_frame_hdr(32'd3);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'h31, 1'b1);
    repeat (4) @(negedge clock);
    chk("len3_wr_count", 32'(wr_cnt - wr_base), 32'd2);
    chk_write("len3_w0", wr_base + 1, 32'h100, 32'h00CCBBAA, 4'b0111);
    chk("len3_halt", 32'(core_halt), 32'd0);
    chk("len3_err", 32'(load_error), 32'd0);

    // Full 8-byte image
    do_reset();
    send_frame_hdr(32'd8);
    for (int i = 1; i <= 8; i++) send_byte(8'(8'h11 * i), 1'b1);
    chk("len8_halt_before_sum", 32'(core_halt), 32'd1);
    send_byte(8'h64, 1'b1);
    repeat (4) @(negedge clock);
    chk("len8_wr_count", 32'(wr_cnt - wr_base), 32'd2);
    chk_write("len8_w0", wr_base, 32'h100, 32'h44332211, 4'hF);
    chk_write("len8_w1", wr_base + 1, 32'h104, 32'h88776655, 4'hF);
    chk("len8_halt", 32'(core_halt), 32'd0);
    chk("len8_err", 32'(load_error), 32'd0);
    // Loaded: line ignored, even framing errors
    send_frame_hdr(32'd1);
    send_byte(8'h77, 1'b0);
    chk("done_ignore_wr", 32'(wr_cnt - wr_base), 32'd2);
    chk("done_ignore_halt", 32'(core_halt), 32'd0);
    chk("done_ignore_err", 32'(load_error), 32'd0);

    // Zero length goes straight to checksum
    do_reset();
    send_frame_hdr(32'd0);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clock);
    chk("len0_halt", 32'(core_halt), 32'd0);
    chk("len0_no_write", 32'(wr_cnt - wr_base), 32'd0);

    // Stalled bus: outputs stay put, second word completion overflows
    do_reset();
    resp_hold = 1'b1;
    send_frame_hdr(32'd8);
    for (int i = 1; i <= 4; i++) send_byte(8'(8'h11 * i), 1'b1);
    fork
      send_byte(8'h55, 1'b1);
      for (int c = 0; c < 200; c++) begin
        @(negedge clock);
        checks++;
        assert ({write_request, rw_address, write_data, write_strobe} ===
                {1'b1, 32'h100, 32'h44332211, 4'hF}) else begin
          errors++;
          $error("FAIL stall_stable cycle %0d: observed %h expected %h", c,
                 {write_request, rw_address, write_data, write_strobe},
                 {1'b1, 32'h100, 32'h44332211, 4'hF});
        end
      end
    join
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    chk("stall_err_before", 32'(load_error), 32'd0);
    send_byte(8'h88, 1'b1);
    repeat (4) @(negedge clock);
    chk("stall_overflow_err", 32'(load_error), 32'd1);
    chk("stall_req_held", 32'(write_request), 32'd1);
    resp_hold = 1'b0;
    repeat (8) @(negedge clock);
    chk("stall_wr_count", 32'(wr_cnt - wr_base), 32'd1);
    chk_write("stall_w0", wr_base, 32'h100, 32'h44332211, 4'hF);
    chk("stall_req_drop", 32'(write_request), 32'd0);
    chk("stall_halt", 32'(core_halt), 32'd1);

    // Reset during a pending write drops the request asynchronously
    do_reset();
    resp_hold = 1'b1;
    send_frame_hdr(32'd8);
    for (int i = 1; i <= 4; i++) send_byte(8'(8'h11 * i), 1'b1);
    chk("rstmid_req_pre", 32'(write_request), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_req_async", 32'(write_request), 32'd0);
    chk("rstmid_halt", 32'(core_halt), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    resp_hold = 1'b0;
    repeat (4) @(negedge clock);
    wr_base = wr_cnt;
    for (int i = 5; i <= 8; i++) send_byte(8'(8'h11 * i), 1'b1);
    repeat (4) @(negedge clock);
    chk("rstmid_stray_wr", 32'(wr_cnt - wr_base), 32'd0);
    chk("rstmid_stray_req", 32'(write_request), 32'd0);
    chk("rstmid_stray_err", 32'(load_error), 32'd0);
    send_frame_hdr(32'd3);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'h31, 1'b1);
    repeat (4) @(negedge clock);
    chk("rstmid_wr_count", 32'(wr_cnt - wr_base), 32'd1);
    chk_write("rstmid_w0", wr_base, 32'h100, 32'h00CCBBAA, 4'b0111);
    chk("rstmid_halt_done", 32'(core_halt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
